// File: rtl/flux_write_pkg.sv
// flux_write_pkg: shared FSM states, precomp classes, delay width and pattern classifier for the flux write path
package flux_write_pkg;
  typedef enum logic [1:0] {IDLE, PRIME, RUN, DRAIN} state_e;
  typedef enum logic [1:0] {NOMINAL, EARLY, LATE} precomp_e;
  localparam int PRECOMP_LIMIT = 63;
  localparam int DLY_W = $clog2(2 * PRECOMP_LIMIT + 2);
  function automatic precomp_e classify(input logic prev2, input logic next2);
    return (prev2 && !next2) ? EARLY : (!prev2 && next2) ? LATE : NOMINAL;
  endfunction
endpackage

// File: rtl/flux_write_pulse_timer.sv
// flux_write_pulse_timer: one-shot delay-then-width pulse timer (load_i/d_i in; pulse_o, busy_o, collision_o out); a reload replaces a pending pulse or cuts an active one
module flux_write_pulse_timer
  import flux_write_pkg::*;
#(
  parameter int PULSE_WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [DLY_W-1:0] d_i,
  output logic             pulse_o,
  output logic             busy_o,
  output logic             collision_o
);
  localparam logic [7:0] WID_LAST = 8'(PULSE_WIDTH - 1);
  logic             pend_q, pend_d, act_q, act_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [7:0]       wid_q, wid_d;
  always_comb begin
    pend_d = pend_q;
    act_d  = act_q;
    dly_d  = dly_q;
    wid_d  = wid_q;
    if (load_i) begin
      pend_d = d_i != '0;
      act_d  = d_i == '0;
      dly_d  = d_i - DLY_W'(1);
      wid_d  = WID_LAST;
    end else if (pend_q) begin
      pend_d = dly_q != '0;
      act_d  = dly_q == '0;
      dly_d  = dly_q - DLY_W'(1);
      wid_d  = WID_LAST;
    end else if (act_q) begin
      act_d = wid_q != '0;
      wid_d = wid_q - 8'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= 1'b0;
      act_q  <= 1'b0;
      dly_q  <= '0;
      wid_q  <= '0;
    end else begin
      pend_q <= pend_d;
      act_q  <= act_d;
      dly_q  <= dly_d;
      wid_q  <= wid_d;
    end
  end
  assign pulse_o     = act_q;
  assign busy_o      = pend_q || act_q;
  assign collision_o = load_i && (pend_q || act_q);
endmodule

// File: rtl/flux_write_pulse_gen.sv
// flux_write_pulse_gen: MFM write pulse generator (enable, nco_step, precomp_delay, cell_data/valid in; cell_ready, wr_pulse, wr_gate, busy, underrun, timing_err out)
module flux_write_pulse_gen
  import flux_write_pkg::*;
#(
  parameter int PULSE_WIDTH = 8,
  parameter int PRECOMP_MAX = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] nco_step,
  input  logic [5:0]  precomp_delay,
  input  logic        cell_data,
  input  logic        cell_valid,
  output logic        cell_ready,
  output logic        wr_pulse,
  output logic        wr_gate,
  output logic        busy,
  output logic        underrun,
  output logic        timing_err
);
  localparam logic [DLY_W-1:0] PMAX = DLY_W'(PRECOMP_MAX);
  state_e           state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic [32:0]      sum;
  logic             bnd_q, bnd_d, counting;
  logic [4:0]       sr_q, sr_d;
  logic             pc_q, pc_d, und_q, und_d, terr_q, terr_d;
  logic [1:0]       dc_q, dc_d;
  logic             accept, shift, in_bit, load, tmr_busy, collision;
  logic [DLY_W-1:0] p, d;
  precomp_e         cls;
  assign counting = state_q == RUN || state_q == DRAIN;
  assign sum      = {1'b0, acc_q} + {1'b0, nco_step};
  assign acc_d    = counting ? sum[31:0] : '0;
  assign bnd_d    = counting && sum[32];
  // a boundary that sees enable low only moves to DRAIN; the two DRAIN shifts flush the last cells to c0
  assign cell_ready = state_q == PRIME || (state_q == RUN && bnd_q && enable);
  assign accept     = cell_valid && cell_ready;
  assign shift      = bnd_q && ((state_q == RUN && enable) || (state_q == DRAIN && dc_q != 2'd2));
  assign in_bit     = state_q == RUN && cell_valid && cell_data;
  // sr = {c+2, c+1, c0, c-1, c-2}; after the shift c0 is sr_q[3] and c-2 is sr_q[1]
  assign load = shift && sr_q[3];
  assign cls  = classify(sr_q[1], in_bit);
  assign p    = (precomp_delay > 6'(PRECOMP_MAX)) ? PMAX : DLY_W'(precomp_delay);
  assign d    = cls == EARLY ? PMAX - p : cls == LATE ? PMAX + p : PMAX;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    dc_d    = dc_q;
    und_d   = und_q || (state_q == RUN && shift && !cell_valid);
    terr_d  = terr_q || collision;
    sr_d    = shift ? {in_bit, sr_q[4:1]} : sr_q;
    case (state_q)
      IDLE: begin
        pc_d = 1'b0;
        dc_d = '0;
        sr_d = '0;
        if (enable) begin
          state_d = PRIME;
          und_d   = 1'b0;
          terr_d  = 1'b0;
        end
      end
      PRIME: begin
        if (!enable) state_d = IDLE;
        else if (accept) begin
          sr_d = {cell_data, sr_q[4:1]};
          pc_d = 1'b1;
          if (pc_q) state_d = RUN;
        end
      end
      RUN: if (bnd_q && !enable) state_d = DRAIN;
      DRAIN: begin
        if (shift) dc_d = dc_q + 2'd1;
        if (dc_q == 2'd2 && !tmr_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      bnd_q   <= 1'b0;
      sr_q    <= '0;
      pc_q    <= 1'b0;
      dc_q    <= '0;
      und_q   <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      bnd_q   <= bnd_d;
      sr_q    <= sr_d;
      pc_q    <= pc_d;
      dc_q    <= dc_d;
      und_q   <= und_d;
      terr_q  <= terr_d;
    end
  end
  flux_write_pulse_timer #(.PULSE_WIDTH(PULSE_WIDTH)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load),
    .d_i        (d),
    .pulse_o    (wr_pulse),
    .busy_o     (tmr_busy),
    .collision_o(collision)
  );
  assign wr_gate    = counting;
  assign busy       = state_q != IDLE;
  assign underrun   = und_q;
  assign timing_err = terr_q;
endmodule

// File: tb/tb_flux_write_pulse_gen.sv
// tb_flux_write_pulse_gen: directed and random write sessions checked against a boundary/pulse-interval model
module tb_flux_write_pulse_gen;
  localparam int PW   = 8;
  localparam int PMAX = 15;
  logic        clk = 1'b0;
  logic        reset, enable, cell_data, cell_valid;
  logic [31:0] nco_step;
  logic [5:0]  precomp_delay;
  logic        cell_ready, wr_pulse, wr_gate, busy, underrun, timing_err;
  int          checks = 0;
  int          errors = 0;
  bit          src[$];
  bit          seen[$];
  bit          exp_p[0:4095];
  bit          exp_g[0:4095];
  bit          exp_b[0:4095];
  always #5 clk = ~clk;
  flux_write_pulse_gen dut (
    .clk(clk), .reset(reset), .enable(enable), .nco_step(nco_step),
    .precomp_delay(precomp_delay), .cell_data(cell_data), .cell_valid(cell_valid),
    .cell_ready(cell_ready), .wr_pulse(wr_pulse), .wr_gate(wr_gate), .busy(busy),
    .underrun(underrun), .timing_err(timing_err)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask
  function automatic bit cell_at(input int i);
    return (i >= 1 && i <= seen.size()) ? seen[i-1] : 1'b0;
  endfunction
  // cycle of boundary k, counted from enable assertion; RUN starts 3 cycles later
  function automatic longint bt(input int k, input logic [31:0] step);
    longint num;
    num = longint'(k) * 64'h1_0000_0000 + longint'(step) - 1;
    return 3 + num / longint'(step);
  endfunction
  task automatic run_case(input string name, input logic [31:0] step, input logic [5:0] pd, input int hole);
    longint ts[$], rs[$];
    longint t, e, last_end, fall, hole_t;
    int     L, p, d, idx, curw, maxw;
    bit     cm2, cp2, eterr, acc;
    seen = src;
    if (hole > 0) seen.insert(hole + 1, 1'b0);
    L = seen.size();
    p = (int'(pd) > PMAX) ? PMAX : int'(pd);
    for (int s = 1; s <= L; s++) begin
      if (cell_at(s)) begin
        cm2 = cell_at(s - 2);
        cp2 = cell_at(s + 2);
        d = (cm2 && !cp2) ? PMAX - p : (!cm2 && cp2) ? PMAX + p : PMAX;
        t = bt((s <= L - 2) ? s : s + 1, step);
        ts.push_back(t);
        rs.push_back(t + d + 1);
      end
    end
    foreach (exp_p[i]) begin
      exp_p[i] = 0;
      exp_g[i] = 0;
      exp_b[i] = 0;
    end
    last_end = 0;
    eterr = 0;
    foreach (rs[i]) begin
      e = rs[i] + PW;
      if (i + 1 < rs.size() && ts[i+1] + 1 < e) e = ts[i+1] + 1;
      for (longint x = rs[i]; x < e; x++) exp_p[x] = 1;
      if (e > rs[i]) last_end = e;
      if (i > 0 && ts[i] < rs[i-1] + PW) eterr = 1;
    end
    fall = bt(L + 1, step) + 2;
    if (last_end + 1 > fall) fall = last_end + 1;
    for (longint x = 1; x < fall; x++) begin
      exp_b[x] = 1;
      exp_g[x] = x >= 3;
    end
    hole_t = (hole > 0) ? bt(hole, step) : -1;
    nco_step = step;
    precomp_delay = pd;
    idx = 0;
    acc = 0;
    curw = 0;
    maxw = 0;
    for (int c = 0; c <= fall + 4; c++) begin
      @(posedge clk);
      #1;
      if (acc) idx++;
      enable = idx < src.size();
      cell_valid = enable && (c != hole_t);
      cell_data = (idx < src.size()) ? src[idx] : 1'b0;
      @(negedge clk);
      acc = cell_valid && cell_ready;
      curw = wr_pulse ? curw + 1 : 0;
      if (curw > maxw) maxw = curw;
      chk($sformatf("%s wr_pulse c%0d", name, c), wr_pulse, exp_p[c]);
      chk($sformatf("%s wr_gate c%0d", name, c), wr_gate, exp_g[c]);
      chk($sformatf("%s busy c%0d", name, c), busy, exp_b[c]);
    end
    chk({name, " underrun"}, underrun, hole > 0);
    chk({name, " timing_err"}, timing_err, eterr);
    chk({name, " width_le_pw"}, maxw <= PW, 1);
  endtask
  initial begin
    bit found, seen_bad;
    int n;
    reset = 1'b1;
    enable = 1'b0;
    cell_valid = 1'b0;
    cell_data = 1'b0;
    nco_step = '0;
    precomp_delay = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst cell_ready", cell_ready, 0);
    chk("rst wr_pulse", wr_pulse, 0);
    chk("rst wr_gate", wr_gate, 0);
    chk("rst busy", busy, 0);
    chk("rst underrun", underrun, 0);
    chk("rst timing_err", timing_err, 0);
    reset = 1'b0;
    src = '{1, 0, 0, 0, 1, 0, 1, 0, 0, 0};
    run_case("basic", 32'h0400_0000, 6'd4, 0);
    run_case("clamp", 32'h0400_0000, 6'd40, 0);
    run_case("underrun", 32'h0400_0000, 6'd4, 3);
    src = '{1, 1, 1, 1, 1, 1, 1, 1};
    run_case("collide", 32'h1000_0000, 6'd4, 0);
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(6, 18);
      src.delete();
      repeat (n) src.push_back($urandom_range(0, 2) == 0);
      run_case($sformatf("rand%0d", r), $urandom_range(32'h0618_0000, 32'h02E0_0000), 6'($urandom_range(0, 63)), 0);
    end
    nco_step = '0;
    @(posedge clk);
    #1;
    enable = 1'b1;
    cell_valid = 1'b1;
    cell_data = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cell_valid = 1'b0;
    seen_bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (wr_pulse || cell_ready) seen_bad = 1;
    end
    chk("stall quiet", seen_bad, 0);
    chk("stall wr_gate", wr_gate, 1);
    chk("stall underrun", underrun, 0);
    reset = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    chk("stall reset busy", busy, 0);
    reset = 1'b0;
    nco_step = 32'h0400_0000;
    precomp_delay = 6'd4;
    @(posedge clk);
    #1;
    enable = 1'b1;
    cell_valid = 1'b1;
    cell_data = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cell_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      found = wr_pulse;
    end
    chk("midrst pulse_seen", found, 1);
    chk("midrst underrun_pre", underrun, 1);
    reset = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    chk("midrst wr_pulse", wr_pulse, 0);
    chk("midrst wr_gate", wr_gate, 0);
    chk("midrst busy", busy, 0);
    chk("midrst underrun", underrun, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    enable = 1'b1;
    cell_valid = 1'b1;
    cell_data = 1'b1;
    @(negedge clk);
    chk("abort idle ready", cell_ready, 0);
    @(negedge clk);
    chk("abort prime ready", cell_ready, 1);
    @(posedge clk);
    #1;
    enable = 1'b0;
    cell_valid = 1'b0;
    seen_bad = 0;
    repeat (150) begin
      @(negedge clk);
      if (wr_gate || wr_pulse) seen_bad = 1;
    end
    chk("abort no gate/pulse", seen_bad, 0);
    chk("abort busy", busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
